// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display mux: active-low hex glyphs {g,f,e,d,c,b,a},
// the all-dark segment pattern and the largest supported digit count.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index = nibble value; b and d are the lowercase forms so they differ from 8 and 0.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = SEG_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment driver with per-frame input snapshot and leading-zero blanking.
// Define SEVEN_SEG_MUX_DIM_EN to add PWM brightness control through the bright input.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int   DIGITS      = 4,
  parameter int   PRESCALE    = 100000,
  parameter logic LZB_DEFAULT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzb_en,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                tick;
  logic                frame_tick;

  logic [4*DIGITS-1:0] snap_value;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_blank;
  logic                snap_lzb;

  logic [DIGITS-1:0]   zero_from;
  logic [3:0]          nibble;
  logic                slot_blank;
  logic                slot_dp;
  logic                slot_zero;
  logic                dark;
  logic                lit;
  logic [6:0]          glyph;

  logic [DIGITS-1:0]   anode_d;
  logic [6:0]          seg_d;
  logic                dp_d;

  assign tick       = (cnt == CNT_LAST);
  assign frame_tick = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Inputs are frozen for a whole frame so a mid-frame update never tears the display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_lzb   <= LZB_DEFAULT;
    end else if (frame_tick) begin
      snap_value <= value;
      snap_dp    <= dp_in;
      snap_blank <= blank;
      snap_lzb   <= lzb_en;
    end
  end

  // zero_from[i]: nibble i and every nibble above it are zero.
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (snap_value[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (snap_value[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nibble     = '0;
    slot_blank = 1'b0;
    slot_dp    = 1'b0;
    slot_zero  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble     = snap_value[4*i +: 4];
        slot_blank = snap_blank[i];
        slot_dp    = snap_dp[i];
        slot_zero  = (i != 0) && zero_from[i];
      end
    end
  end

  assign dark = slot_blank || (snap_lzb && slot_zero);

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .glyph  (glyph)
  );

`ifdef SEVEN_SEG_MUX_DIM_EN
  logic [CW+4:0] dim_lhs;
  logic [CW+4:0] dim_rhs;

  // On-time within a slot is (bright+1)/16 of the slot; bright=15 keeps the digit on throughout.
  assign dim_lhs = {1'b0, cnt, 4'b0000};
  assign dim_rhs = (CW+5)'({1'b0, bright} + 5'd1) * (CW+5)'(PRESCALE);
  assign lit     = (dim_lhs < dim_rhs);
`else
  logic unused_bright;

  assign unused_bright = ^bright;
  assign lit           = 1'b1;
`endif

  always_comb begin
    anode_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      anode_d[i] = !((idx == IW'(i)) && !dark && lit);
    end
    seg_d = dark ? SEG_OFF : glyph;
    dp_d  = dark ? 1'b1 : !slot_dp;
  end

  // Anode, segments and dp share one register stage so they always switch together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode       <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= frame_tick;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux (DIGITS=4); frames are checked cycle by cycle against a reference model.
module tb_seven_seg_mux;

`ifdef SEVEN_SEG_MUX_DIM_EN
  localparam int PS = 16;
`else
  localparam int PS = 4;
`endif
  localparam int ND = 4;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lzb_en;
  logic [3:0]  bright;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int          n_vec;
  int          n_err;
  logic [12:0] exp_q[$];

  seven_seg_mux #(
    .DIGITS      (ND),
    .PRESCALE    (PS),
    .LZB_DEFAULT (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .blank       (blank),
    .lzb_en      (lzb_en),
    .bright      (bright),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Expected {frame_start, anode, seg, dp} for cycle c of digit slot d.
  function automatic logic [12:0] model(input logic [15:0] v, input logic [3:0] dpv,
                                        input logic [3:0] blk, input logic lzb,
                                        input logic [3:0] br, input int d, input int c);
    logic       dark;
    logic       on;
    logic       fs;
    logic [3:0] an;
    logic [6:0] sg;
    logic       dpo;
    dark = blk[d] || (lzb && (d != 0) && ((v >> (4 * d)) == 16'h0));
    on   = 1'b1;
`ifdef SEVEN_SEG_MUX_DIM_EN
    on   = (c * 16) < ((int'(br) + 1) * PS);
`else
    if (br == 4'hX) on = 1'b0;
`endif
    an   = (dark || !on) ? 4'hF : ~(4'b0001 << d);
    sg   = dark ? 7'h7F : glyph(v[4*d +: 4]);
    dpo  = dark ? 1'b1 : !dpv[d];
    fs   = (d == ND - 1) && (c == PS - 1);
    return {fs, an, sg, dpo};
  endfunction

  // Driver: check one whole frame; optionally change value at sample chg_at.
  task automatic run_frame(input string tag, input logic [15:0] v, input logic [3:0] dpv,
                           input logic [3:0] blk, input logic lzb, input logic [3:0] br,
                           input int chg_at, input logic [15:0] chg_val);
    logic [12:0] e;
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < PS; c++)
        exp_q.push_back(model(v, dpv, blk, lzb, br, d, c));
    for (int k = 0; k < ND * PS; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, {19'd0, frame_start, anode, seg, dp}, {19'd0, e});
      if (k == chg_at) value = chg_val;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    value  = 16'h0000;
    dp_in  = 4'b0000;
    blank  = 4'b0000;
    lzb_en = 1'b0;
    bright = 4'hF;
    #1 reset = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_anode", anode, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_frame_start", frame_start, 1'b0);

    value = 16'h1234;
    reset = 1'b0;
    // First frame after reset shows the zeroed snapshot.
    run_frame("power_up", 16'h0000, 4'b0000, 4'b0000, 1'b0, bright, -1, 16'h0);

    value  = 16'h0050;
    lzb_en = 1'b1;
    run_frame("glyphs_1234", 16'h1234, 4'b0000, 4'b0000, 1'b0, bright, -1, 16'h0);

    value  = 16'h1111;
    lzb_en = 1'b0;
    run_frame("lzb_0050", 16'h0050, 4'b0000, 4'b0000, 1'b1, bright, -1, 16'h0);

    run_frame("no_tear_1111", 16'h1111, 4'b0000, 4'b0000, 1'b0, bright, 9, 16'h2222);

    dp_in = 4'b0100;
    blank = 4'b0010;
    run_frame("next_2222", 16'h2222, 4'b0000, 4'b0000, 1'b0, bright, -1, 16'h0);

`ifdef SEVEN_SEG_MUX_DIM_EN
    bright = 4'd3;
`endif
    run_frame("dp_blank", 16'h2222, 4'b0100, 4'b0010, 1'b0, bright, -1, 16'h0);
    bright = 4'hF;

    // Into the digit 2 slot of the next frame, then reset asynchronously.
    repeat (2 * PS + 1) @(negedge clk);
    check("pre_rst_anode", anode, 4'hB);
    check("pre_rst_dp", dp, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_anode", anode, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp", dp, 1'b1);
    check("async_rst_frame_start", frame_start, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_frame("post_reset", 16'h0000, 4'b0000, 4'b0000, 1'b0, bright, -1, 16'h0);
    run_frame("after_reset", 16'h2222, 4'b0100, 4'b0010, 1'b0, bright, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
